// File: rtl/simon_audio_pkg.sv
// Shared types and constants for the Simon tone generator.
// Note codes, phase increments, FSM states and codec divider values.
package simon_audio_pkg;

    typedef enum logic [2:0] {
        NOTE_GREEN  = 3'd0,
        NOTE_RED    = 3'd1,
        NOTE_YELLOW = 3'd2,
        NOTE_BLUE   = 3'd3,
        NOTE_ERROR  = 3'd4
    } note_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_PLAY,
        ST_DONE
    } state_e;

    localparam int BCK_DIV    = 12;
    localparam int FRAME_LEN  = 384;
    localparam int FRAME_LAST = 383;

    localparam logic [3:0] BCK_LAST = 4'(BCK_DIV - 1);
    localparam logic [3:0] BCK_HALF = 4'(BCK_DIV / 2);
    localparam logic [8:0] TICK_CNT = 9'(FRAME_LAST);
    localparam logic [8:0] LR_HALF  = 9'(FRAME_LEN / 2);

    // 16-bit phase step per 48 kHz sample; codes 5-7 are silent.
    function automatic logic [15:0] phase_inc(input logic [2:0] note);
        logic [15:0] inc;
        case (note)
            NOTE_GREEN:  inc = 16'd566;
            NOTE_RED:    inc = 16'd423;
            NOTE_YELLOW: inc = 16'd344;
            NOTE_BLUE:   inc = 16'd285;
            NOTE_ERROR:  inc = 16'd57;
            default:     inc = 16'd0;
        endcase
        return inc;
    endfunction

endpackage

// File: rtl/audio_clk_gen.sv
// Codec frame timing: 384-cycle frame, bit clock /12, LR clock /384.
// Emits the one-cycle sample tick on the last cycle of each frame.
module audio_clk_gen
    import simon_audio_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_bck,
    output logic o_lrck,
    output logic o_tick
);

    logic [8:0] r_fcnt;
    logic [3:0] r_bcnt;

    // 384 is a multiple of 12, so the two counters never drift apart.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_fcnt <= '0;
            r_bcnt <= '0;
        end else begin
            r_fcnt <= (r_fcnt == TICK_CNT) ? 9'd0 : r_fcnt + 9'd1;
            r_bcnt <= (r_bcnt == BCK_LAST) ? 4'd0 : r_bcnt + 4'd1;
        end
    end

    assign o_bck  = (r_bcnt >= BCK_HALF);
    assign o_lrck = (r_fcnt < LR_HALF);
    assign o_tick = (r_fcnt == TICK_CNT);

endmodule

// File: rtl/simon_tone_gen.sv
// Simon game tone generator: square-wave notes streamed to a 48 kHz codec.
// Define TONE_ENVELOPE_EN to add a linear attack/release gain envelope.
module simon_tone_gen
    import simon_audio_pkg::*;
#(
    parameter logic [15:0] AMPLITUDE   = 16'h2000,
    parameter int          DUR_SAMPLES = 24000
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iSTART,
    input  logic [2:0]  iNOTE,
    output logic        oBUSY,
    output logic        oDONE,
    output logic        AUD_BCK,
    output logic        AUD_DACLRCK,
    output logic [15:0] AUD_outL,
    output logic [15:0] AUD_outR
);

    localparam logic [23:0] DUR = 24'(DUR_SAMPLES);

    state_e      r_state;
    state_e      w_next_state;
    logic [2:0]  r_note;
    logic [15:0] r_phase;
    logic [15:0] r_sample;
    logic [23:0] r_cnt;

    logic        w_tick;
    logic        w_end;
    logic        w_audible;
    logic [23:0] w_k;
    logic [15:0] w_phase_n;
    logic [15:0] w_mag;
    logic [15:0] w_sample_n;

    audio_clk_gen u_clk_gen (
        .i_clk   (iCLK),
        .i_rst_n (iRST_N),
        .o_bck   (AUD_BCK),
        .o_lrck  (AUD_DACLRCK),
        .o_tick  (w_tick)
    );

    always_ff @(posedge iCLK) begin
        if (!iRST_N) r_state <= ST_IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: if (iSTART)          w_next_state = ST_ARM;
            ST_ARM:  if (w_tick)          w_next_state = ST_PLAY;
            ST_PLAY: if (w_tick && w_end) w_next_state = ST_DONE;
            ST_DONE:                      w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        oBUSY = 1'b0;
        oDONE = 1'b0;
        unique case (r_state)
            ST_ARM, ST_PLAY: oBUSY = 1'b1;
            ST_DONE:         oDONE = 1'b1;
            default:         ;
        endcase
    end

    // Frame index and phase of the sample written at the current tick.
    assign w_k       = (r_state == ST_ARM) ? 24'd0 : r_cnt + 24'd1;
    assign w_phase_n = (r_state == ST_ARM) ? 16'd0
                                           : r_phase + phase_inc(r_note);
    assign w_end     = (w_k == DUR);
    assign w_audible = ((r_state == ST_ARM) ||
                        (r_state == ST_PLAY && !w_end)) &&
                       (r_note <= NOTE_ERROR);

`ifdef TONE_ENVELOPE_EN
    logic [23:0] w_rem;
    logic [7:0]  w_gain;

    // Release ramp takes over once fewer than 256 frames remain.
    assign w_rem  = DUR - w_k;
    assign w_gain = (w_rem <= 24'd255) ? w_rem[7:0]
                  : (w_k >= 24'd255)   ? 8'd255
                  :                      w_k[7:0];
    assign w_mag  = 16'((24'(AMPLITUDE) * 24'(w_gain)) >> 8);
`else
    assign w_mag  = AMPLITUDE;
`endif

    assign w_sample_n = !w_audible      ? 16'h0000
                      : w_phase_n[15]   ? -w_mag
                      :                   w_mag;

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_note   <= '0;
            r_phase  <= '0;
            r_cnt    <= '0;
            r_sample <= '0;
        end else begin
            if (r_state == ST_IDLE && iSTART) r_note <= iNOTE;
            if (w_tick) begin
                r_sample <= w_sample_n;
                if (r_state == ST_ARM || r_state == ST_PLAY) begin
                    r_phase <= w_phase_n;
                    r_cnt   <= w_k;
                end
            end
        end
    end

    assign AUD_outL = r_sample;
    assign AUD_outR = r_sample;

endmodule

// File: tb/tb_simon_tone_gen.sv
// Randomized bench for simon_tone_gen against a frame-timeline reference.
// Checks codec clocks, busy/done and every output sample each cycle.
module tb_simon_tone_gen;

    localparam int          DUR   = 60;
    localparam int          FRAME = 384;
    localparam logic [15:0] AMP   = 16'h2000;

    logic        iCLK = 1'b0;
    logic        iRST_N;
    logic        iSTART;
    logic [2:0]  iNOTE;
    logic        oBUSY;
    logic        oDONE;
    logic        AUD_BCK;
    logic        AUD_DACLRCK;
    logic [15:0] AUD_outL;
    logic [15:0] AUD_outR;

    simon_tone_gen #(
        .AMPLITUDE   (AMP),
        .DUR_SAMPLES (DUR)
    ) dut (
        .iCLK        (iCLK),
        .iRST_N      (iRST_N),
        .iSTART      (iSTART),
        .iNOTE       (iNOTE),
        .oBUSY       (oBUSY),
        .oDONE       (oDONE),
        .AUD_BCK     (AUD_BCK),
        .AUD_DACLRCK (AUD_DACLRCK),
        .AUD_outL    (AUD_outL),
        .AUD_outR    (AUD_outR)
    );

    always #5 iCLK = ~iCLK;

    int n_cmp = 0;
    int n_bad = 0;
    int n     = 0;
    bit m_act = 1'b0;
    int m_acc = 0;
    int m_t0  = 0;
    int m_tend = 0;
    int m_note = 0;
    int inc_tbl [5] = '{566, 423, 344, 285, 57};

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (edge %0d)",
                     tag, got, exp, n);
        end
    endtask

    // Sample of audible frame k of the current tone.
    function automatic logic [15:0] ref_sample(input int k);
        int ph;
        int mag;
`ifdef TONE_ENVELOPE_EN
        int rem;
        int gain;
`endif
        if (m_note > 4) return 16'h0000;
        ph  = (k * inc_tbl[m_note]) % 65536;
        mag = int'(AMP);
`ifdef TONE_ENVELOPE_EN
        rem  = DUR - k;
        gain = (rem <= 255) ? rem : ((k < 255) ? k : 255);
        mag  = (int'(AMP) * gain) / 256;
`endif
        return (ph < 32768) ? 16'(mag) : 16'(-mag);
    endfunction

    // One clock: update the timeline model at the edge, compare at negedge.
    task automatic step();
        logic        e_busy;
        logic        e_done;
        logic [15:0] e_s;
        @(posedge iCLK);
        if (!iRST_N) begin
            n     = 0;
            m_act = 1'b0;
        end else begin
            n++;
            if (iSTART && !(m_act && (n - 1) <= m_tend)) begin
                m_act  = 1'b1;
                m_acc  = n;
                m_note = int'(iNOTE);
                m_t0   = ((n + FRAME) / FRAME) * FRAME;
                m_tend = m_t0 + FRAME * DUR;
            end
        end
        @(negedge iCLK);
        e_busy = 1'b0;
        e_done = 1'b0;
        e_s    = 16'h0000;
        if (m_act) begin
            e_busy = (n >= m_acc) && (n < m_tend);
            e_done = (n == m_tend);
            if (n >= m_t0 && n < m_tend)
                e_s = ref_sample((n - m_t0) / FRAME);
        end
        check("bck",  32'(AUD_BCK),     32'((n % 12) >= 6));
        check("lrck", 32'(AUD_DACLRCK), 32'((n % FRAME) < FRAME / 2));
        check("busy", 32'(oBUSY),       32'(e_busy));
        check("done", 32'(oDONE),       32'(e_done));
        check("outL", 32'(AUD_outL),    32'(e_s));
        check("outR", 32'(AUD_outR),    32'(e_s));
    endtask

    task automatic start(input logic [2:0] note);
        iSTART = 1'b1;
        iNOTE  = note;
        step();
        iSTART = 1'b0;
        iNOTE  = 3'($urandom_range(0, 7));
    endtask

    task automatic finish_tone();
        while (n < m_tend + 3) step();
    endtask

    initial begin
        iRST_N = 1'b0;
        iSTART = 1'b0;
        iNOTE  = 3'd0;
        repeat (3) step();
        iRST_N = 1'b1;
        repeat (2 * FRAME + $urandom_range(0, 50)) step();

        // Note 0 long enough to reach negative half-cycles; restart ignored.
        start(3'd0);
        repeat ($urandom_range(FRAME * 5, FRAME * 40)) step();
        start(3'($urandom_range(0, 7)));
        finish_tone();

        // Silent code, then a start in the done cycle that must be dropped.
        start(3'($urandom_range(5, 7)));
        while (n < m_tend) step();
        start(3'($urandom_range(0, 4)));
        repeat (FRAME + 5) step();

        // Abort a tone with a one-cycle reset.
        start(3'($urandom_range(0, 4)));
        repeat ($urandom_range(FRAME + 1, FRAME * 8)) step();
        iRST_N = 1'b0;
        step();
        iRST_N = 1'b1;
        repeat ($urandom_range(10, 500)) step();

        // A normal tone after the abort.
        start(3'($urandom_range(0, 7)));
        finish_tone();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/simon_tone_gen.md
SIMON_TONE_GEN -- requirements
Module: simon_tone_gen

Interface
REQ-001 Parameter AMPLITUDE, 16'h2000: peak magnitude of the square wave, two's complement.
REQ-002 Parameter DUR_SAMPLES, 24000: tone length in 48 kHz samples (0.5 s).
REQ-003 iCLK  in  1  18.432 MHz system clock, the only clock; all logic on its rising edge.
REQ-004 iRST_N  in  1  reset, synchronous, active-low.
REQ-005 iSTART  in  1  one-cycle request to play iNOTE.
REQ-006 iNOTE  in  3  0 green, 1 red, 2 yellow, 3 blue, 4 error buzz, 5-7 silent tone.
REQ-007 oBUSY  out  1  high from accepted start until tone end.
REQ-008 oDONE  out  1  one-cycle pulse when a tone finishes.
REQ-009 AUD_BCK  out  1  audio bit clock, iCLK/12.
REQ-010 AUD_DACLRCK  out  1  left/right clock, iCLK/384 (48 kHz); high = left.
REQ-011 AUD_outL, AUD_outR  out  16 each  two's-complement sample to the serialiser; always equal (mono).

Function
REQ-012 Frame counter fcnt SHALL count 0..383 and wrap to 0; AUD_BCK = 0 for fcnt mod 12 in 0..5, else 1; AUD_DACLRCK = 1 for fcnt 0..191, else 0.
REQ-013 Sample tick SHALL be the single cycle with fcnt == 383; the samples change only on the edge ending that cycle, so they are stable for the whole following frame (16 BCK falls per channel).
REQ-014 FSM states IDLE, ARM, PLAY, DONE.
REQ-015 IDLE: iSTART=1 -> latch iNOTE, assert oBUSY next cycle, go ARM.
REQ-016 ARM: on sample tick -> clear phase accumulator and sample counter, go PLAY.
REQ-017 PLAY: on each tick add the note increment to 16-bit phase (modulo 2^16) and increment the sample counter; the tick on which the counter reaches DUR_SAMPLES -> go DONE.
REQ-018 Phase increments: 566, 423, 344, 285, 57 for notes 0-4 (415, 310, 252, 209, 42 Hz); notes 5-7 increment 0 and output 0.
REQ-019 Sample in PLAY = +AMPLITUDE when phase[15]=0, else -AMPLITUDE; in IDLE, ARM, DONE = 16'h0000, written at the next tick.
REQ-020 DONE: oDONE=1 for exactly one cycle, oBUSY drops the same cycle, go IDLE.
REQ-021 iSTART while oBUSY=1 SHALL be ignored (no restart, no queue); iSTART in the DONE cycle is ignored.
REQ-022 Tone latency: the first nonzero sample appears at the first tick after acceptance. Audible length SHALL be exactly DUR_SAMPLES frames.

Reset
REQ-023 iRST_N=0 at any iCLK edge SHALL force: fcnt=0, FSM=IDLE, phase=0, sample counter=0, oBUSY=0, oDONE=0, AUD_outL=AUD_outR=0, AUD_BCK=0, AUD_DACLRCK=1.
REQ-024 Reset mid-tone SHALL abort the tone with no oDONE pulse.

Configuration
REQ-025 Macro TONE_ENVELOPE_EN defined: 8-bit gain; it rises by 1 per tick from 0 and saturates at 255. When remaining samples <= 255, gain = remaining. Sample = ±((AMPLITUDE*gain)>>8), product computed 24-bit.
REQ-026 Without TONE_ENVELOPE_EN: no gain logic; sample = ±AMPLITUDE exactly.

Structure
REQ-027 Package simon_audio_pkg SHALL hold note codes, the phase-increment table, the FSM state typedef, and the divider constants 12/384/383.
REQ-028 Sub-module audio_clk_gen SHALL contain fcnt, AUD_BCK, AUD_DACLRCK and the sample-tick output; the rest stays in simon_tone_gen.

Verification
REQ-029 Release reset, no start -> AUD_BCK period 12 iCLK, AUD_DACLRCK period 384 iCLK (192 high), outputs 0, oBUSY=0.
REQ-030 iSTART with iNOTE=0, DUR_SAMPLES=100 -> oBUSY next cycle; 100 frames of ±16'h2000 with phase[15] toggling about every 58 frames; single oDONE; then 0.
REQ-031 iSTART with iNOTE=6 -> oBUSY for DUR_SAMPLES frames, outputs stay 0, oDONE pulse.
REQ-032 Second iSTART with iNOTE=1 mid-tone of note 3 -> ignored; note 3 completes full length with one oDONE.
REQ-033 iRST_N low for 1 cycle mid-tone -> all outputs at reset values next edge, no oDONE, later start works normally.
REQ-034 TONE_ENVELOPE_EN, DUR_SAMPLES=600 -> |sample| for frames 0,1,128 = 0,32,4096; final frame |sample| = 32; without macro all 16'h2000.
